// File: rtl/ls_queue_wb_pkg.sv
// ls_pkg: shared definitions for the load/store queue with write-back cache.
//   - ls_op_e    : memory op encodings (LB..SW)
//   - ls_state_e : cache miss-handling FSM states
//   - width helpers derived from the block parameters
//   - is_store / acc_bytes : op decode helpers
package ls_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVICT,
        ST_REFILL
    } ls_state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int line_bytes, input int sets);
        return 32 - $clog2(line_bytes) - $clog2(sets);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // LHU is the only op with bit 2 set that is not a store.
    function automatic logic is_store(input logic [2:0] op);
        return op[2] && (op != OP_LHU);
    endfunction

    function automatic logic [2:0] acc_bytes(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ls_queue_wb_if.sv
// ls_queue_wb_if: line-granular memory controller bus.
//   mem_valid/mem_we/mem_addr/mem_wline : request from the queue (master)
//   mem_ready (1-cycle pulse) / mem_rline : completion and refill data (slave)
interface ls_queue_wb_if #(
    parameter int LINE_BYTES = 16
) ();
    logic                    mem_valid;
    logic                    mem_we;
    logic [31:0]             mem_addr;
    logic [8*LINE_BYTES-1:0] mem_wline;
    logic                    mem_ready;
    logic [8*LINE_BYTES-1:0] mem_rline;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wline,
        input  mem_ready, mem_rline
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wline,
        output mem_ready, mem_rline
    );
endinterface

// File: rtl/ls_queue_wb_load_extend.sv
// load_extend: combinational load result extension.
//   op    : load op (LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through)
//   raw   : data with the addressed byte in bits [7:0]
//   value : extended 32-bit result
module load_extend
    import ls_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] value
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = signed'(raw[7:0]);
    assign half_s = signed'(raw[15:0]);

    always_comb begin
        value = raw;
        case (op)
            OP_LB:   value = {{24{byte_s[7]}}, byte_s};
            OP_LH:   value = {{16{half_s[15]}}, half_s};
            OP_LBU:  value = {24'd0, raw[7:0]};
            OP_LHU:  value = {16'd0, raw[15:0]};
            default: value = raw;
        endcase
    end
endmodule

// File: rtl/ls_queue_wb.sv
// ls_queue_wb: in-order load/store queue with a direct-mapped write-back cache.
//   clk, rst (async, active-low), rdy (global hold when low)
//   issue_*          : enqueue port (issue_dest != 0 enqueues)
//   lsb_*, rss_*     : result buses used for operand wakeup
//   rob_flush        : drop all uncommitted entries
//   rob_store_commit : one store committed this cycle
//   out_dest/value   : load result (out_dest is a one-cycle pulse)
//   mem              : memory controller bus (eviction writes, refills)
//   full             : issuer stall
module ls_queue_wb
    import ls_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ROB_ID_W   = 4,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ROB_ID_W-1:0] issue_dest,
    input  logic [2:0]          issue_op,
    input  logic [ROB_ID_W-1:0] issue_qj,
    input  logic [ROB_ID_W-1:0] issue_qk,
    input  logic [31:0]         issue_vj,
    input  logic [31:0]         issue_vk,
    input  logic [31:0]         issue_imm,
    input  logic [ROB_ID_W-1:0] lsb_dest,
    input  logic [31:0]         lsb_value,
    input  logic [ROB_ID_W-1:0] rss_dest,
    input  logic [31:0]         rss_value,
    input  logic                rob_flush,
    input  logic                rob_store_commit,
    output logic [ROB_ID_W-1:0] out_dest,
    output logic [31:0]         out_value,
    output logic                full,
    ls_queue_wb_if.master       mem
);
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(LINE_BYTES, SETS);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = 8 * LINE_BYTES;

    logic [2:0]          q_op        [DEPTH];
    logic [ROB_ID_W-1:0] q_dest      [DEPTH];
    logic [ROB_ID_W-1:0] q_qj        [DEPTH];
    logic [ROB_ID_W-1:0] q_qk        [DEPTH];
    logic [31:0]         q_vj        [DEPTH];
    logic [31:0]         q_vk        [DEPTH];
    logic [31:0]         q_imm       [DEPTH];
    logic                q_addr_done [DEPTH];

    logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
    logic [CNT_W-1:0] count, commit_cnt, count_nxt, commit_nxt;

    logic              c_valid [SETS];
    logic              c_dirty [SETS];
    logic [TAG_W-1:0]  c_tag   [SETS];
    logic [LINE_W-1:0] c_data  [SETS];

    ls_state_e   state, state_nxt;
    logic [31:0] miss_addr;   // line being fetched; survives a flush of the head
    logic [IDX_W-1:0] miss_idx;

    logic [DEPTH-1:0] busy;
    logic             agen_vld;
    logic [PTR_W-1:0] agen_idx;
    logic             enq, retire, do_load, do_store;
    logic             start_evict, start_refill, evict_done, refill_done;

    logic [31:0]       h_addr, h_raw, h_ext;
    logic [OFF_W-1:0]  h_off;
    logic [IDX_W-1:0]  h_idx;
    logic [TAG_W-1:0]  h_tag;
    logic              h_ready, h_hit, h_store, store_ok;
    logic [LINE_W-1:0] st_line;

    function automatic logic [PTR_W-1:0] rel_pos(input logic [PTR_W-1:0] idx);
        return idx - head;
    endfunction

    // Bus snoop: lsb is checked first so it wins a double match.
    function automatic logic [ROB_ID_W+31:0] resolve(input logic [ROB_ID_W-1:0] tag,
                                                     input logic [31:0] val);
        if (tag != '0 && tag == lsb_dest) return {ROB_ID_W'(0), lsb_value};
        if (tag != '0 && tag == rss_dest) return {ROB_ID_W'(0), rss_value};
        return {tag, val};
    endfunction

    // Occupancy is derived from head/count so a flush only has to move tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            busy[i] = {1'b0, rel_pos(PTR_W'(i))} < count;
    end

    // Scan downwards so the lowest ready index is the one left standing.
    always_comb begin
        agen_vld = 1'b0;
        agen_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (busy[i] && q_qj[i] == '0 && !q_addr_done[i]) begin
                agen_vld = 1'b1;
                agen_idx = PTR_W'(i);
            end
        end
    end

    assign h_addr   = q_vj[head];
    assign h_off    = h_addr[OFF_W-1:0];
    assign h_idx    = h_addr[OFF_W +: IDX_W];
    assign h_tag    = h_addr[31 -: TAG_W];
    assign h_ready  = busy[head] && q_addr_done[head];
    assign h_hit    = c_valid[h_idx] && (c_tag[h_idx] == h_tag);
    assign h_store  = is_store(q_op[head]);
    assign store_ok = (q_qk[head] == '0) && (commit_cnt != '0 || rob_store_commit);
    assign h_raw    = 32'(c_data[h_idx] >> {h_off, 3'b000});
    assign miss_idx = miss_addr[OFF_W +: IDX_W];

    load_extend u_ext (
        .op    (q_op[head]),
        .raw   (h_raw),
        .value (h_ext)
    );

    // Little-endian byte merge of the head store into its cache line.
    always_comb begin
        st_line = c_data[h_idx];
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (b >= int'(h_off) && b < int'(h_off) + int'(acc_bytes(q_op[head])))
                st_line[8*b +: 8] = q_vk[head][8*((b - int'(h_off)) & 3) +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state <= ST_IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        do_load      = 1'b0;
        do_store     = 1'b0;
        start_evict  = 1'b0;
        start_refill = 1'b0;
        evict_done   = 1'b0;
        refill_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (h_ready) begin
                    if (h_hit) begin
                        if (!h_store)     do_load  = 1'b1;
                        else if (store_ok) do_store = 1'b1;
                    end else if (c_valid[h_idx] && c_dirty[h_idx]) begin
                        start_evict = 1'b1;
                        state_nxt   = ST_EVICT;
                    end else begin
                        start_refill = 1'b1;
                        state_nxt    = ST_REFILL;
                    end
                end
            end
            ST_EVICT: begin
                if (mem.mem_ready) begin
                    evict_done = 1'b1;
                    state_nxt  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem.mem_ready) begin
                    refill_done = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign retire = do_load || do_store;
    assign enq    = (issue_dest != '0) && (count != CNT_W'(DEPTH)) && !rob_flush;

    // A same-cycle commit is added before a flush truncates to the committed stores.
    always_comb begin
        commit_nxt = commit_cnt + CNT_W'(rob_store_commit) - CNT_W'(do_store);
        head_nxt   = head + PTR_W'(retire);
        if (rob_flush) begin
            count_nxt = commit_nxt;
            tail_nxt  = head_nxt + PTR_W'(commit_nxt);
        end else begin
            count_nxt = count + CNT_W'(enq) - CNT_W'(retire);
            tail_nxt  = tail + PTR_W'(enq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_cnt    <= '0;
            full          <= 1'b0;
            out_dest      <= '0;
            out_value     <= '0;
            miss_addr     <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wline <= '0;
            for (int s = 0; s < SETS; s++) begin
                c_valid[s] <= 1'b0;
                c_dirty[s] <= 1'b0;
            end
        end else if (rdy) begin
            head       <= head_nxt;
            tail       <= tail_nxt;
            count      <= count_nxt;
            commit_cnt <= commit_nxt;
            full       <= count_nxt >= CNT_W'(DEPTH - 1);
            out_dest   <= (do_load && !rob_flush) ? q_dest[head] : '0;
            if (do_load)  out_value <= h_ext;
            if (do_store) c_dirty[h_idx] <= 1'b1;
            if (start_evict) begin
                mem.mem_valid <= 1'b1;
                mem.mem_we    <= 1'b1;
                mem.mem_addr  <= {c_tag[h_idx], h_idx, OFF_W'(0)};
                mem.mem_wline <= c_data[h_idx];
                miss_addr     <= {h_tag, h_idx, OFF_W'(0)};
            end
            if (start_refill) begin
                mem.mem_valid <= 1'b1;
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= {h_tag, h_idx, OFF_W'(0)};
                miss_addr     <= {h_tag, h_idx, OFF_W'(0)};
            end
            // Victim written back: turn the same request into the refill read.
            if (evict_done) begin
                c_dirty[miss_idx] <= 1'b0;
                mem.mem_we        <= 1'b0;
                mem.mem_addr      <= miss_addr;
            end
            if (refill_done) begin
                c_valid[miss_idx] <= 1'b1;
                c_dirty[miss_idx] <= 1'b0;
                mem.mem_valid     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (refill_done) begin
                c_data[miss_idx] <= mem.mem_rline;
                c_tag[miss_idx]  <= miss_addr[31 -: TAG_W];
            end
            if (do_store) c_data[h_idx] <= st_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && PTR_W'(i) == tail) begin
                    q_op[i]             <= issue_op;
                    q_dest[i]           <= issue_dest;
                    {q_qj[i], q_vj[i]}  <= resolve(issue_qj, issue_vj);
                    {q_qk[i], q_vk[i]}  <= resolve(issue_qk, issue_vk);
                    q_imm[i]            <= issue_imm;
                    q_addr_done[i]      <= 1'b0;
                end else if (busy[i]) begin
                    {q_qj[i], q_vj[i]} <= resolve(q_qj[i], q_vj[i]);
                    {q_qk[i], q_vk[i]} <= resolve(q_qk[i], q_vk[i]);
                    if (agen_vld && agen_idx == PTR_W'(i)) begin
                        q_vj[i]        <= q_vj[i] + q_imm[i];
                        q_addr_done[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ls_queue_wb.sv
// tb_ls_queue_wb: directed self-checking bench for ls_queue_wb
// (DEPTH=16, ROB_ID_W=4, LINE_BYTES=16, SETS=16).
module tb_ls_queue_wb;
    import ls_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [3:0]  issue_dest = '0, issue_qj = '0, issue_qk = '0;
    logic [2:0]  issue_op = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0, issue_imm = '0;
    logic [3:0]  lsb_dest = '0, rss_dest = '0;
    logic [31:0] lsb_value = '0, rss_value = '0;
    logic        rob_flush = 1'b0, rob_store_commit = 1'b0;
    logic [3:0]  out_dest;
    logic [31:0] out_value;
    logic        full;

    int checks   = 0;
    int failures = 0;

    ls_queue_wb_if #(.LINE_BYTES(16)) mem_bus ();

    ls_queue_wb #(.DEPTH(16), .ROB_ID_W(4), .LINE_BYTES(16), .SETS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .issue_dest       (issue_dest),
        .issue_op         (issue_op),
        .issue_qj         (issue_qj),
        .issue_qk         (issue_qk),
        .issue_vj         (issue_vj),
        .issue_vk         (issue_vk),
        .issue_imm        (issue_imm),
        .lsb_dest         (lsb_dest),
        .lsb_value        (lsb_value),
        .rss_dest         (rss_dest),
        .rss_value        (rss_value),
        .rob_flush        (rob_flush),
        .rob_store_commit (rob_store_commit),
        .out_dest         (out_dest),
        .out_value        (out_value),
        .full             (full),
        .mem              (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] dest, input logic [2:0] op, input logic [3:0] qj,
                         input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm);
        issue_dest = dest; issue_op = op; issue_qj = qj; issue_qk = qk;
        issue_vj = vj; issue_vk = vk; issue_imm = imm;
        step();
        issue_dest = '0; issue_qj = '0; issue_qk = '0;
    endtask

    task automatic wait_req(input string tag, input logic we, input logic [31:0] addr);
        int n = 0;
        while (mem_bus.mem_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, mem_bus.mem_valid, 1);
        check({tag, "_we"}, mem_bus.mem_we, we);
        check({tag, "_addr"}, mem_bus.mem_addr, addr);
    endtask

    task automatic mem_done(input logic [127:0] line);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rline = line;
        step();
        mem_bus.mem_ready = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [3:0] dest, input logic [31:0] value);
        int n = 0;
        while (out_dest === 4'd0 && n < 60) begin
            step();
            n++;
        end
        check({tag, "_dest"}, out_dest, dest);
        check({tag, "_value"}, out_value, value);
    endtask

    initial begin
        logic [127:0] ln;
        int           nloads;
        int           n;
        logic         first;

        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rline = '0;
        rdy = 1'b1;
        step();
        step();
        check("rst_out_dest", out_dest, 0);
        check("rst_out_value", out_value, 0);
        check("rst_mem_valid", mem_bus.mem_valid, 0);
        check("rst_mem_we", mem_bus.mem_we, 0);
        check("rst_mem_addr", mem_bus.mem_addr, 0);
        check("rst_mem_wline", mem_bus.mem_wline, 0);
        check("rst_full", full, 0);
        rst = 1'b1;
        step();

        // Cold LW 0x104 -> refill of line 0x100 (byte i = i) -> 0x07060504
        issue(4'd1, OP_LW, 4'd0, 4'd0, 32'h100, 32'h0, 32'h4);
        wait_req("t1_req", 1'b0, 32'h100);
        for (int i = 0; i < 16; i++) ln[8*i +: 8] = 8'(i);
        mem_done(ln);
        check("t1_gap", out_dest, 0);
        step();
        check("t1_dest", out_dest, 1);
        check("t1_value", out_value, 32'h07060504);
        step();
        check("t1_pulse", out_dest, 0);

        // SB 0x80 to 0x200 (clean victim 0x100 in set 0), then LB / LBU
        issue(4'd2, OP_SB, 4'd0, 4'd0, 32'h200, 32'h80, 32'h0);
        rob_store_commit = 1'b1;
        step();
        rob_store_commit = 1'b0;
        wait_req("t2_req", 1'b0, 32'h200);
        mem_done(128'h0);
        issue(4'd3, OP_LB, 4'd0, 4'd0, 32'h200, 32'h0, 32'h0);
        wait_out("t2_lb", 4'd3, 32'hFFFFFF80);
        issue(4'd4, OP_LBU, 4'd0, 4'd0, 32'h200, 32'h0, 32'h0);
        wait_out("t2_lbu", 4'd4, 32'h00000080);

        // LW 0x300 hits dirty set 0 (tag 2): evict 0x200 first, then refill 0x300
        issue(4'd5, OP_LW, 4'd0, 4'd0, 32'h300, 32'h0, 32'h0);
        wait_req("t3_evict", 1'b1, 32'h200);
        check("t3_wline", mem_bus.mem_wline, 128'h80);
        mem_done(128'h0);
        wait_req("t3_refill", 1'b0, 32'h300);
        mem_done(128'hDEADBEEF);
        wait_out("t3_lw", 4'd5, 32'hDEADBEEF);

        // Two stores, only the first committed, then flush
        issue(4'd6, OP_SW, 4'd0, 4'd7, 32'h300, 32'h0, 32'h0);
        issue(4'd8, OP_SW, 4'd0, 4'd0, 32'h304, 32'h22222222, 32'h0);
        rob_store_commit = 1'b1;
        step();
        rob_store_commit = 1'b0;
        rob_flush = 1'b1;
        step();
        rob_flush = 1'b0;
        check("t4_count", dut.count, 1);
        lsb_dest = 4'd7; lsb_value = 32'h11111111;
        step();
        lsb_dest = 4'd0;
        issue(4'd9, OP_LW, 4'd0, 4'd0, 32'h304, 32'h0, 32'h0);
        wait_out("t4_dropped", 4'd9, 32'h0);
        issue(4'd10, OP_LW, 4'd0, 4'd0, 32'h300, 32'h0, 32'h0);
        wait_out("t4_kept", 4'd10, 32'h11111111);

        // Issue-cycle bypass from rss: base comes from the bus, address 0x40
        rss_dest = 4'd5; rss_value = 32'h40;
        issue(4'd11, OP_LW, 4'd5, 4'd0, 32'h0, 32'h0, 32'h0);
        rss_dest = 4'd0;
        wait_req("t5_req", 1'b0, 32'h40);
        mem_done(128'h12345678);
        wait_out("t5_lw", 4'd11, 32'h12345678);
        step();

        // Fill with 15 blocked loads, then release them
        for (int k = 0; k < 14; k++) issue(4'd1, OP_LW, 4'd12, 4'd0, 32'h0, 32'h0, 32'h0);
        check("t5_full14", full, 0);
        issue(4'd1, OP_LW, 4'd12, 4'd0, 32'h0, 32'h0, 32'h0);
        check("t5_full15", full, 1);
        rss_dest = 4'd12; rss_value = 32'h40;
        step();
        rss_dest = 4'd0;
        nloads = 0;
        n = 0;
        first = 1'b1;
        while (nloads < 15 && n < 300) begin
            step();
            n++;
            if (out_dest !== 4'd0) begin
                if (first) begin
                    check("t5_full_drop", full, 0);
                    check("t5_drain_value", out_value, 32'h12345678);
                    first = 1'b0;
                end
                nloads++;
            end
        end
        check("t5_drained", nloads, 15);

        // Reset in the middle of a refill
        issue(4'd13, OP_LW, 4'd0, 4'd0, 32'h580, 32'h0, 32'h0);
        wait_req("t6_req", 1'b0, 32'h580);
        rst = 1'b0;
        #1;
        check("t6_mem_valid", mem_bus.mem_valid, 0);
        check("t6_mem_addr", mem_bus.mem_addr, 0);
        check("t6_mem_we", mem_bus.mem_we, 0);
        check("t6_out_dest", out_dest, 0);
        check("t6_out_value", out_value, 0);
        check("t6_full", full, 0);
        rst = 1'b1;
        step();
        issue(4'd14, OP_LW, 4'd0, 4'd0, 32'h40, 32'h0, 32'h0);
        wait_req("t6_remiss", 1'b0, 32'h40);
        mem_done(128'hABCD0123);
        wait_out("t6_lw", 4'd14, 32'hABCD0123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ls_queue_wb.md
Name: ls_queue_wb

Overview:
- Parametrised in-order load/store queue with an integrated direct-mapped write-back data cache.
- Sits between the issuer, the two result buses (lsb, rss), the ROB commit/flush bus and the memory controller.
- Generalises the existing fixed 16-entry design in depth, line size and set count.
- Adds what that design lacks: dirty-victim eviction before refill, store data forwarding from the buses, and flush that keeps committed stores.

Parameters:
- DEPTH, 16, queue entries (power of 2, ≥4).
- ROB_ID_W, 4, ROB tag width; tag 0 means "no tag / value ready".
- LINE_BYTES, 16, cache line size in bytes (power of 2, ≥4).
- SETS, 16, cache sets (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- issue_dest  in  ROB_ID_W  nonzero = enqueue this cycle.
- issue_op  in  3  LB/LH/LW/LBU/LHU/SB/SH/SW.
- issue_qj, issue_qk  in  ROB_ID_W  pending base / store-data tags.
- issue_vj, issue_vk  in  32  base / store-data values.
- issue_imm  in  32  address offset.
- lsb_dest, rss_dest  in  ROB_ID_W  bus tags (0 = idle).
- lsb_value, rss_value  in  32  bus values.
- rob_flush  in  1  mispredict flush.
- rob_store_commit  in  1  one store committed this cycle.
- out_dest  out  ROB_ID_W  load result tag (0 = none).
- out_value  out  32  extended load result.
- mem_valid  out  1  memory request.
- mem_we  out  1  1 = line write.
- mem_addr  out  32  line-aligned address.
- mem_wline  out  8*LINE_BYTES  write line.
- mem_ready  in  1  request done (one-cycle pulse).
- mem_rline  in  8*LINE_BYTES  refill data.
- full  out  1  issuer must stall.

Behaviour:
- Reset (rst=0, async): queue empty; head=tail=0; commit_cnt=0; cache valid/dirty cleared; FSM=IDLE; out_dest=0, out_value=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wline=0, full=0.
- full = count ≥ DEPTH-1 (registered). An enqueue when count=DEPTH is dropped; the bench flags it.
- Operand wakeup:
  - Each cycle every busy entry whose qj/qk matches a nonzero lsb_dest or rss_dest takes that value and clears the tag.
  - Issue in the same cycle as a matching broadcast captures the broadcast value (bypass).
  - If both buses match the same tag, lsb wins.
- Address calc: the lowest-index busy entry with qj=0 and !addr_done gets vj<=vj+imm (mod 2^32) and addr_done<=1. One entry per cycle.
- FSM IDLE, head busy, addr_done:
  - Hit, load: out_dest/out_value registered next cycle (1-cycle load latency); head advances.
  - Hit, store: proceeds only when qk=0 and (commit_cnt>0 or rob_store_commit). Writes bytes, sets dirty, head advances, commit_cnt decrements; a simultaneous commit makes the net change 0.
  - Miss, victim dirty: go to EVICT; mem_valid=1, mem_we=1, mem_addr={victim_tag,index,0}, mem_wline=victim line.
  - Miss, victim clean: go to REFILL; mem_valid=1, mem_we=0, mem_addr=line address.
- EVICT, on mem_ready: clear dirty; issue the refill request next cycle; go to REFILL.
- REFILL, on mem_ready: write line, tag, valid=1, dirty=0; mem_valid=0; go to IDLE; the access retries (hit).
- out_dest is a single-cycle pulse; out_dest=0 whenever no load retires.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged. Accesses are naturally aligned and never cross a line.
- Byte order: little-endian within the line.
- Flush (rob_flush):
  - Drops every entry beyond the first commit_cnt entries from head; tail = head+commit_cnt; count = commit_cnt.
  - Clears out_dest.
  - A commit in the same cycle is counted before truncation.
  - An EVICT/REFILL in flight completes; the cache is never invalidated by flush.
- Wrap-around: head/tail modulo DEPTH. Enqueue and retire in the same cycle leave count unchanged.
- Invariant: commit_cnt ≤ count.

Decomposition:
- Package ls_pkg holds:
  - op encodings (LB=0..SW=7, IS_STORE = op[2]&&op!=LBU/LHU decoded by a function);
  - FSM state enum (IDLE, EVICT, REFILL);
  - derived widths: offset=log2(LINE_BYTES), index=log2(SETS), tag=32-offset-index, ptr=log2(DEPTH).
- Sub-module load_extend (combinational byte/half/word sign/zero extension) is shared with the rest of the design.

Test Plan:
- Cold LW at vj=0x100, imm=4, empty cache → REFILL request at 0x100. After mem_ready with line bytes i=i, out_value=0x07060504 two cycles later.
- SB 0x80 to 0x200, committed, then LB 0x200 → hit, out_value=0xFFFFFF80. Then LBU 0x200 → out_value=0x00000080.
- Dirty line at set 0 (tag A), LW mapping to set 0 with tag B → EVICT write of A's line with mem_we=1 first, then REFILL read of B, then out_dest is asserted.
- Two stores queued, one committed, then rob_flush → count=1. The committed store retires; the second store never writes the cache (a later load returns the old value).
- Issue with qj=5 in the same cycle as rss_dest=5, value=0x40, imm=0 → address 0x40 used; fill to DEPTH-1 entries → full=1, and full=0 after one retire.
- Assert rst low during REFILL → all outputs are at reset values immediately; a subsequent load misses again.
